// File: rtl/instr_decoder.sv
// Registered 32-bit instruction decoder: field slicing, one-hot class flags, ALU sub-op and write enable.
// Optional read-after-write hazard output is enabled with the DECODER_HAZARD_EN macro.
module instr_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        inst_valid,
   output logic [2:0]  opcode,
   output logic [4:0]  reg_addr_0,
   output logic [4:0]  reg_addr_1,
   output logic [4:0]  reg_addr_2,
   output logic [14:0] addr,
   output logic        out_valid,
   output logic        is_nop,
   output logic        is_load,
   output logic        is_store,
   output logic        is_jump,
   output logic        is_alu,
   output logic [1:0]  alu_op,
`ifdef DECODER_HAZARD_EN
   output logic        raw_hazard,
`endif
   output logic        writes_reg
);

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_STORE = 3'd2,
      OP_JUMP  = 3'd3,
      OP_ADD   = 3'd4,
      OP_SUB   = 3'd5,
      OP_AND   = 3'd6,
      OP_OR    = 3'd7
   } opcode_e;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [4:0]  reg_addr_0;
      logic [4:0]  reg_addr_1;
      logic [4:0]  reg_addr_2;
      logic [14:0] addr;
      logic        is_nop;
      logic        is_load;
      logic        is_store;
      logic        is_jump;
      logic        is_alu;
      logic [1:0]  alu_op;
      logic        writes_reg;
   } dec_t;

   dec_t dec_new;
   dec_t dec_d, dec_q;
   logic out_valid_d, out_valid_q;

   // reg_addr_2 and addr intentionally overlap on inst[14].
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      dec_new            = '0;
      dec_new.opcode     = inst[31:29];
      dec_new.reg_addr_0 = inst[28:24];
      dec_new.reg_addr_1 = inst[23:19];
      dec_new.reg_addr_2 = inst[18:14];
      dec_new.addr       = inst[14:0];
      unique case (opcode_e'(inst[31:29]))
         OP_NOP:   dec_new.is_nop = 1'b1;
         OP_LOAD: begin
            dec_new.is_load    = 1'b1;
            dec_new.writes_reg = 1'b1;
         end
         OP_STORE: dec_new.is_store = 1'b1;
         OP_JUMP:  dec_new.is_jump  = 1'b1;
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            dec_new.is_alu     = 1'b1;
            dec_new.writes_reg = 1'b1;
            dec_new.alu_op     = inst[30:29];
         end
      endcase
   end

   always_comb begin
      dec_d       = dec_q;
      out_valid_d = 1'b0;
      if (inst_valid) begin
         dec_d       = dec_new;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         dec_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         dec_q       <= dec_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign opcode     = dec_q.opcode;
   assign reg_addr_0 = dec_q.reg_addr_0;
   assign reg_addr_1 = dec_q.reg_addr_1;
   assign reg_addr_2 = dec_q.reg_addr_2;
   assign addr       = dec_q.addr;
   assign is_nop     = dec_q.is_nop;
   assign is_load    = dec_q.is_load;
   assign is_store   = dec_q.is_store;
   assign is_jump    = dec_q.is_jump;
   assign is_alu     = dec_q.is_alu;
   assign alu_op     = dec_q.alu_op;
   assign writes_reg = dec_q.writes_reg;
   assign out_valid  = out_valid_q;

`ifdef DECODER_HAZARD_EN
   logic [4:0] prev_dest_d, prev_dest_q;
   logic       prev_writes_d, prev_writes_q;
   logic       raw_hazard_d, raw_hazard_q;
   logic       hit_a, hit_b;

   // History only advances on accepted instructions; register 0 is compared like any other.
   always_comb begin
      hit_a         = prev_writes_q && (prev_dest_q == dec_new.reg_addr_1);
      hit_b         = prev_writes_q && (prev_dest_q == dec_new.reg_addr_2);
      prev_dest_d   = prev_dest_q;
      prev_writes_d = prev_writes_q;
      raw_hazard_d  = raw_hazard_q;
      if (inst_valid) begin
         prev_dest_d   = dec_new.reg_addr_0;
         prev_writes_d = dec_new.writes_reg;
         raw_hazard_d  = (dec_new.is_alu && (hit_a || hit_b)) || (dec_new.is_store && hit_a);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_dest_q   <= '0;
         prev_writes_q <= 1'b0;
         raw_hazard_q  <= 1'b0;
      end else begin
         prev_dest_q   <= prev_dest_d;
         prev_writes_q <= prev_writes_d;
         raw_hazard_q  <= raw_hazard_d;
      end
   end

   assign raw_hazard = raw_hazard_q;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed cases then randomized stimulus against a spec-level model.
// Define DECODER_HAZARD_EN to also check raw_hazard.
module tb_instr_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = 32'h0;
   logic        inst_valid = 1'b0;
   logic [2:0]  opcode;
   logic [4:0]  reg_addr_0, reg_addr_1, reg_addr_2;
   logic [14:0] addr;
   logic        out_valid, is_nop, is_load, is_store, is_jump, is_alu, writes_reg;
   logic [1:0]  alu_op;
`ifdef DECODER_HAZARD_EN
   logic        raw_hazard;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   instr_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .inst       (inst),
      .inst_valid (inst_valid),
      .opcode     (opcode),
      .reg_addr_0 (reg_addr_0),
      .reg_addr_1 (reg_addr_1),
      .reg_addr_2 (reg_addr_2),
      .addr       (addr),
      .out_valid  (out_valid),
      .is_nop     (is_nop),
      .is_load    (is_load),
      .is_store   (is_store),
      .is_jump    (is_jump),
      .is_alu     (is_alu),
      .alu_op     (alu_op),
`ifdef DECODER_HAZARD_EN
      .raw_hazard (raw_hazard),
`endif
      .writes_reg (writes_reg)
   );

   always #5 clk = ~clk;

   // Reference model state: the value each output should show, plus hazard history.
   logic [31:0] m_inst;       // last accepted instruction word
   logic        m_any;        // an instruction has been accepted since reset
   logic        m_valid;
   logic        m_hazard;
   int          m_prev_dest;
   bit          m_prev_writes;

   function automatic bit writes_of(input int op);
      return (op == 1) || (op >= 4);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input logic [31:0] w);
      int op, ra1, ra2;
      bit reads_a, reads_b;
      if (r) begin
         m_inst = 32'h0; m_any = 0; m_valid = 0; m_hazard = 0;
         m_prev_dest = 0; m_prev_writes = 0;
      end else if (v) begin
         op  = int'(w[31:29]);
         ra1 = int'(w[23:19]);
         ra2 = int'(w[18:14]);
         reads_a = (op >= 4) || (op == 2);
         reads_b = (op >= 4);
         m_hazard = m_prev_writes && ((reads_a && ra1 == m_prev_dest) || (reads_b && ra2 == m_prev_dest));
         m_prev_dest   = int'(w[28:24]);
         m_prev_writes = writes_of(op);
         m_inst = w; m_any = 1; m_valid = 1;
      end else begin
         m_valid = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      int op;
      op = int'(m_inst[31:29]);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".opcode"},    32'(opcode),     32'(m_inst[31:29]));
      check({tag, ".ra0"},       32'(reg_addr_0), 32'(m_inst[28:24]));
      check({tag, ".ra1"},       32'(reg_addr_1), 32'(m_inst[23:19]));
      check({tag, ".ra2"},       32'(reg_addr_2), 32'(m_inst[18:14]));
      check({tag, ".addr"},      32'(addr),       32'(m_inst[14:0]));
      check({tag, ".is_nop"},    32'(is_nop),     32'(m_any && op == 0));
      check({tag, ".is_load"},   32'(is_load),    32'(m_any && op == 1));
      check({tag, ".is_store"},  32'(is_store),   32'(m_any && op == 2));
      check({tag, ".is_jump"},   32'(is_jump),    32'(m_any && op == 3));
      check({tag, ".is_alu"},    32'(is_alu),     32'(m_any && op >= 4));
      check({tag, ".alu_op"},    32'(alu_op),     (m_any && op >= 4) ? 32'(op - 4) : 32'd0);
      check({tag, ".writes"},    32'(writes_reg), 32'(m_any && writes_of(op)));
      check({tag, ".onehot"},    32'($countones({is_nop, is_load, is_store, is_jump, is_alu})), 32'(m_any));
`ifdef DECODER_HAZARD_EN
      check({tag, ".hazard"},    32'(raw_hazard), 32'(m_hazard));
`endif
   endtask

   task automatic step(input string tag, input bit r, input bit v, input logic [31:0] w);
      rst = r; inst_valid = v; inst = w;
      @(posedge clk);
      model_step(r, v, w);
      #1;
      compare_all(tag);
   endtask

   function automatic logic [31:0] mk(input int op, input int rd, input int ra, input int rb);
      logic [31:0] w;
      w = $urandom;
      w[31:29] = 3'(op);
      w[28:24] = 5'(rd);
      w[23:19] = 5'(ra);
      w[18:14] = 5'(rb);
      return w;
   endfunction

   initial begin
      logic [31:0] w;
      bit r, v;

      // Reset dominates a valid all-ones instruction.
      step("reset0", 1'b1, 1'b1, 32'hFFFF_FFFF);
      step("reset1", 1'b1, 1'b1, 32'hFFFF_FFFF);
      check("reset.exact_opcode", 32'(opcode), 32'd0);

      step("add", 1'b0, 1'b1, 32'h8008_8000);
      check("add.ra2_is_2", 32'(reg_addr_2), 32'd2);
      check("add.addr_zero", 32'(addr), 32'd0);
      step("load", 1'b0, 1'b1, 32'h2500_1234);
      check("load.addr_1234", 32'(addr), 32'h1234);
      step("idle", 1'b0, 1'b0, 32'hDEAD_BEEF);
      check("idle.ra0_held", 32'(reg_addr_0), 32'd5);

      for (int op = 0; op < 8; op++) step($sformatf("sweep%0d", op), 1'b0, 1'b1, mk(op, op, op + 1, op + 2));

      // Shared bit 14 between reg_addr_2 and addr.
      step("bit14", 1'b0, 1'b1, 32'h0000_4000);
      check("bit14.ra2", 32'(reg_addr_2), 32'd1);

      // Mid-stream reset clears history.
      step("pre_rst", 1'b0, 1'b1, mk(4, 3, 1, 2));
      step("mid_rst", 1'b1, 1'b1, mk(5, 7, 3, 3));
      step("post_rst", 1'b0, 1'b1, mk(5, 7, 3, 3));

      // Hazard scenarios (checked by the model whenever the feature is built in).
      step("hz_add", 1'b0, 1'b1, mk(4, 3, 1, 2));
      step("hz_sub", 1'b0, 1'b1, mk(5, 4, 3, 9));
      step("hz_jump", 1'b0, 1'b1, mk(3, 4, 4, 4));
      step("hz_add2", 1'b0, 1'b1, mk(4, 6, 4, 4));
      step("hz_add3", 1'b0, 1'b1, mk(4, 3, 1, 2));
      step("hz_idle", 1'b0, 1'b0, 32'h0);
      step("hz_store", 1'b0, 1'b1, mk(2, 8, 3, 9));
      step("hz_r0a", 1'b0, 1'b1, mk(1, 0, 5, 5));
      step("hz_r0b", 1'b0, 1'b1, mk(6, 1, 2, 0));

      // Randomized stream with a small register pool so hazards occur often.
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 39) == 0);
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1)
            w = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            w = $urandom;
         step("rand", r, v, w);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
